// File: rtl/write_driver.sv
// SRAM row write sequencer: precharge, wordline drive with complementary bitline
// levels, then a recover cycle that drops the wordline before releasing the data.
module write_driver #(
   parameter int ROWS         = 16,
   parameter int COLS         = 8,
   parameter int PRE_CYCLES   = 1,
   parameter int DRIVE_CYCLES = 2,
   parameter int AW           = $clog2(ROWS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_req,
   input  logic [AW-1:0]   wr_addr,
   input  logic [COLS-1:0] wr_data,
   output logic            wr_ready,
   output logic            wr_done,
   output logic            wr_err,
   output real             row_wr [0:ROWS-1],
   output real             bl_wr  [0:COLS-1],
   output real             blb_wr [0:COLS-1]
);

   localparam real VDD = 1.5;
   localparam real VSS = 0.0;

   localparam int CMAX = (PRE_CYCLES > DRIVE_CYCLES) ? PRE_CYCLES : DRIVE_CYCLES;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

   localparam logic [CW-1:0] PRE_LOAD = CW'(PRE_CYCLES - 1);
   localparam logic [CW-1:0] DRV_LOAD = CW'(DRIVE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [AW:0]   ROWS_L   = (AW + 1)'(ROWS);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRECHARGE = 2'd1,
      DRIVE     = 2'd2,
      RECOVER   = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [COLS-1:0] data_q, data_d;

   logic            ready_d;
   logic            done_d;
   logic            err_d;
   real             row_d [0:ROWS-1];
   real             bl_d  [0:COLS-1];
   real             blb_d [0:COLS-1];

   function automatic real level(input logic b);
      return b ? VDD : VSS;
   endfunction

   // Sequencing: accept/reject in IDLE, one down-counter times PRECHARGE and DRIVE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (wr_req) begin
               if ({1'b0, wr_addr} < ROWS_L) begin
                  state_d = PRECHARGE;
                  cnt_d   = PRE_LOAD;
                  addr_d  = wr_addr;
                  data_d  = wr_data;
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         PRECHARGE: begin
            if (cnt_q == CNT_ZERO) begin
               state_d = DRIVE;
               cnt_d   = DRV_LOAD;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         DRIVE: begin
            if (cnt_q == CNT_ZERO) begin
               state_d = RECOVER;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         RECOVER: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // Output levels for the upcoming cycle, derived from the next state so they register in step.
   always_comb begin
      ready_d = (state_d == IDLE);
      done_d  = (state_d == RECOVER);
      for (int r = 0; r < ROWS; r++) begin
         row_d[r] = ((state_d == DRIVE) && (addr_d == AW'(r))) ? VDD : VSS;
      end
      // Bitlines keep the data through RECOVER so the wordline always falls first.
      for (int c = 0; c < COLS; c++) begin
         if ((state_d == DRIVE) || (state_d == RECOVER)) begin
            bl_d[c]  = level(data_d[c]);
            blb_d[c] = level(~data_d[c]);
         end else begin
            bl_d[c]  = VDD;
            blb_d[c] = VDD;
         end
      end
   end

   // State, latches and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= CNT_ZERO;
         addr_q   <= {AW{1'b0}};
         data_q   <= {COLS{1'b0}};
         wr_ready <= 1'b1;
         wr_done  <= 1'b0;
         wr_err   <= 1'b0;
         for (int r = 0; r < ROWS; r++) begin
            row_wr[r] <= VSS;
         end
         for (int c = 0; c < COLS; c++) begin
            bl_wr[c]  <= VDD;
            blb_wr[c] <= VDD;
         end
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         wr_ready <= ready_d;
         wr_done  <= done_d;
         wr_err   <= err_d;
         for (int r = 0; r < ROWS; r++) begin
            row_wr[r] <= row_d[r];
         end
         for (int c = 0; c < COLS; c++) begin
            bl_wr[c]  <= bl_d[c];
            blb_wr[c] <= blb_d[c];
         end
      end
   end

endmodule

// File: tb/tb_write_driver.sv
// Directed bench for write_driver: phase-based reference model, per-cycle compare,
// array/sense loopback and a second instance with a non-power-of-2 row count.
module tb_write_driver;

   localparam int  ROWS = 16;
   localparam int  COLS = 8;
   localparam int  P    = 1;
   localparam int  D    = 2;
   localparam real VDD  = 1.5;
   localparam real VSS  = 0.0;
   localparam real VTH  = 0.8;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_req;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       wr_ready, wr_done, wr_err;
   real        row_wr [0:ROWS-1];
   real        bl_wr  [0:COLS-1];
   real        blb_wr [0:COLS-1];

   logic       req12;
   logic [3:0] addr12;
   logic [7:0] data12;
   logic       ready12, done12, err12;
   real        row12 [0:11];
   real        bl12  [0:COLS-1];
   real        blb12 [0:COLS-1];

   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   int         done_cnt = 0;
   int         done_cyc [$];
   logic [7:0] mem [0:ROWS-1];
   bit         chk_en = 1'b0;

   bit         m_busy = 1'b0;
   int         m_age  = 0;
   int         m_addr = 0;
   logic [7:0] m_data = 8'h00;
   bit         m_err  = 1'b0;

   always #5 clk = ~clk;

   write_driver #(.ROWS(ROWS), .COLS(COLS), .PRE_CYCLES(P), .DRIVE_CYCLES(D)) dut (
      .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ready(wr_ready), .wr_done(wr_done), .wr_err(wr_err),
      .row_wr(row_wr), .bl_wr(bl_wr), .blb_wr(blb_wr)
   );

   write_driver #(.ROWS(12), .COLS(COLS), .PRE_CYCLES(P), .DRIVE_CYCLES(D)) dut12 (
      .clk(clk), .rst(rst), .wr_req(req12), .wr_addr(addr12), .wr_data(data12),
      .wr_ready(ready12), .wr_done(done12), .wr_err(err12),
      .row_wr(row12), .bl_wr(bl12), .blb_wr(blb12)
   );

   task automatic chk_int(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_real(input string nm, input real act, input real exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %f expected %f (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference model: a write is an age counter since accept; phases follow from age.
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      m_err <= 1'b0;
      if (rst) begin
         m_busy <= 1'b0;
         m_age  <= 0;
      end else if (!m_busy) begin
         if (wr_req) begin
            if (int'(wr_addr) < ROWS) begin
               m_busy <= 1'b1;
               m_age  <= 1;
               m_addr <= int'(wr_addr);
               m_data <= wr_data;
            end else begin
               m_err <= 1'b1;
            end
         end
      end else if (m_age == P + D + 1) begin
         m_busy <= 1'b0;
      end else begin
         m_age <= m_age + 1;
      end
   end

   // Every-cycle comparison of the main instance against the model, plus line invariants.
   always @(negedge clk) begin
      if (chk_en) begin
         bit  drv, held;
         int  bad, nhigh;
         real er;
         drv  = m_busy && (m_age > P) && (m_age <= P + D);
         held = m_busy && (m_age > P);
         chk_int("ready", wr_ready, !m_busy);
         chk_int("done", wr_done, m_busy && (m_age == P + D + 1));
         chk_int("err", wr_err, m_err);
         bad = -1;
         for (int r = 0; r < ROWS; r++) begin
            er = (drv && r == m_addr) ? VDD : VSS;
            if (row_wr[r] != er && bad < 0) bad = r;
         end
         if (bad >= 0) chk_real($sformatf("row_wr[%0d]", bad), row_wr[bad],
                                (drv && bad == m_addr) ? VDD : VSS);
         else n_tests++;
         bad = -1;
         for (int c = 0; c < COLS; c++) begin
            er = held ? (m_data[c] ? VDD : VSS) : VDD;
            if (bl_wr[c] != er && bad < 0) bad = c;
            er = held ? (m_data[c] ? VSS : VDD) : VDD;
            if (blb_wr[c] != er && bad < 0) bad = c + 100;
         end
         if (bad >= 100) chk_real($sformatf("blb_wr[%0d]", bad - 100), blb_wr[bad-100],
                                  held ? (m_data[bad-100] ? VSS : VDD) : VDD);
         else if (bad >= 0) chk_real($sformatf("bl_wr[%0d]", bad), bl_wr[bad],
                                     held ? (m_data[bad] ? VDD : VSS) : VDD);
         else n_tests++;
         nhigh = 0;
         for (int r = 0; r < ROWS; r++) if (row_wr[r] > VTH) nhigh++;
         bad = 0;
         if (nhigh > 0)
            for (int c = 0; c < COLS; c++) if (bl_wr[c] == blb_wr[c]) bad = 1;
         chk_int("one_wordline", nhigh <= 1, 1'b1);
         chk_int("wl_vs_equal_pair", bad, 0);
      end
   end

   // Array model with sense threshold, and wr_done pulse log.
   always @(negedge clk) begin
      for (int r = 0; r < ROWS; r++)
         if (row_wr[r] > VTH)
            for (int c = 0; c < COLS; c++)
               mem[r][c] = (bl_wr[c] > VTH) && (blb_wr[c] < VTH);
      if (wr_done === 1'b1) begin
         done_cnt++;
         done_cyc.push_back(cyc);
      end
   end

   initial begin
      int d0, n0, nh;
      for (int r = 0; r < ROWS; r++) mem[r] = 8'h77;
      rst = 1'b1; wr_req = 1'b0; wr_addr = 4'd0; wr_data = 8'h00;
      req12 = 1'b0; addr12 = 4'd0; data12 = 8'h00;
      step(1);
      chk_en = 1'b1;
      step(1);
      rst = 1'b0;
      step(3);
      chk_real("idle row0", row_wr[0], 0.0);
      chk_real("idle row15", row_wr[15], 0.0);
      chk_real("idle bl3", bl_wr[3], 1.5);
      chk_real("idle blb3", blb_wr[3], 1.5);
      chk_int("idle ready", wr_ready, 1'b1);
      chk_int("idle done", wr_done, 1'b0);
      chk_int("idle err", wr_err, 1'b0);

      // Write row 5 with A5, inputs scrambled right after accept.
      wr_req = 1'b1; wr_addr = 4'd5; wr_data = 8'hA5;
      step(1);
      wr_req = 1'b0; wr_addr = 4'd0; wr_data = 8'h00;
      chk_real("k1 row5", row_wr[5], 0.0);
      chk_real("k1 bl1", bl_wr[1], 1.5);
      chk_int("k1 ready", wr_ready, 1'b0);
      step(1);
      chk_real("k2 row5", row_wr[5], 1.5);
      chk_real("k2 bl7", bl_wr[7], 1.5);
      chk_real("k2 bl6", bl_wr[6], 0.0);
      chk_real("k2 bl1", bl_wr[1], 0.0);
      chk_real("k2 bl0", bl_wr[0], 1.5);
      chk_real("k2 blb6", blb_wr[6], 1.5);
      chk_real("k2 blb0", blb_wr[0], 0.0);
      step(1);
      chk_real("k3 row5", row_wr[5], 1.5);
      step(1);
      chk_int("k4 done", wr_done, 1'b1);
      chk_real("k4 row5", row_wr[5], 0.0);
      chk_real("k4 bl6 held", bl_wr[6], 0.0);
      step(1);
      chk_int("k5 ready", wr_ready, 1'b1);
      chk_int("k5 done", wr_done, 1'b0);
      chk_real("k5 bl6", bl_wr[6], 1.5);
      chk_int("mem5", mem[5], 8'hA5);

      // Inputs changing and a request during DRIVE are ignored.
      d0 = done_cnt;
      wr_req = 1'b1; wr_addr = 4'd2; wr_data = 8'h3C;
      step(1);
      wr_req = 1'b0;
      step(1);
      wr_req = 1'b1; wr_addr = 4'd9; wr_data = 8'hFF;
      step(2);
      wr_req = 1'b0;
      step(2);
      chk_int("single done", done_cnt - d0, 1);
      chk_int("mem2", mem[2], 8'h3C);
      chk_int("mem9 untouched", mem[9], 8'h77);

      // Reset during DRIVE of row 3, then a normal write to row 7.
      wr_req = 1'b1; wr_addr = 4'd3; wr_data = 8'hC3;
      step(1);
      wr_req = 1'b0;
      step(1);
      chk_real("pre-rst row3", row_wr[3], 1.5);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk_real("rst row3", row_wr[3], 0.0);
      chk_real("rst bl0", bl_wr[0], 1.5);
      chk_real("rst blb1", blb_wr[1], 1.5);
      chk_int("rst done", wr_done, 1'b0);
      d0 = done_cnt;
      step(3);
      chk_int("no done after rst", done_cnt, d0);
      wr_req = 1'b1; wr_addr = 4'd7; wr_data = 8'h5A;
      step(1);
      wr_req = 1'b0;
      step(5);
      chk_int("mem7", mem[7], 8'h5A);
      chk_int("row7 done", done_cnt - d0, 1);

      // 12-row instance: out-of-range request rejected, then row 11 accepted.
      req12 = 1'b1; addr12 = 4'd13; data12 = 8'hFF;
      step(1);
      req12 = 1'b0;
      nh = 0;
      for (int r = 0; r < 12; r++) if (row12[r] > VTH) nh++;
      chk_int("r12 err", err12, 1'b1);
      chk_int("r12 ready", ready12, 1'b1);
      chk_int("r12 rows low", nh, 0);
      step(1);
      chk_int("r12 err pulse", err12, 1'b0);
      chk_int("r12 ready2", ready12, 1'b1);
      req12 = 1'b1; addr12 = 4'd11; data12 = 8'h81;
      step(1);
      req12 = 1'b0;
      chk_int("r12 err none", err12, 1'b0);
      step(1);
      chk_real("r12 row11", row12[11], 1.5);
      chk_real("r12 bl0", bl12[0], 1.5);
      chk_real("r12 bl1", bl12[1], 0.0);
      chk_real("r12 blb7", blb12[7], 0.0);
      step(2);
      chk_int("r12 done", done12, 1'b1);
      chk_real("r12 row11 low", row12[11], 0.0);
      step(1);
      chk_int("r12 ready back", ready12, 1'b1);

      // Back-to-back with wr_req held high, alternating rows 0/15.
      d0 = done_cnt;
      n0 = done_cyc.size();
      for (int i = 0; i < 4; i++) begin
         wr_req  = 1'b1;
         wr_addr = (i % 2 == 1) ? 4'd15 : 4'd0;
         wr_data = (i % 2 == 1) ? 8'hFF : 8'h00;
         step(5);
      end
      wr_req = 1'b0;
      step(2);
      chk_int("b2b count", done_cnt - d0, 4);
      if (done_cyc.size() >= n0 + 4)
         for (int j = 1; j < 4; j++)
            chk_int($sformatf("b2b spacing%0d", j), done_cyc[n0+j] - done_cyc[n0+j-1], 5);
      chk_int("mem0", mem[0], 8'h00);
      chk_int("mem15", mem[15], 8'hFF);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
